// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_alu_pkg
// Brief  : Opcode and FSM state encodings shared by seq_alu and seq_alu_iter.
// Rev    : 1.0
// ============================================================================
package seq_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_alu_iter.sv
`default_nettype none
// ============================================================================
// Module : seq_alu_iter
// Brief  : WIDTH-step shift-add multiplier / restoring divider datapath.
//          Divider path only exists when SEQ_ALU_DIV_EN is defined.
// Rev    : 1.0
// ============================================================================
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   w_sum;
`ifdef SEQ_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   w_shl, w_diff;
`endif

    // done fires on the final step so the caller can latch lo_o/hi_o (next values) that edge
    assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        w_sum  = {1'b0, hi_q} + {1'b0, b_q};
`ifdef SEQ_ALU_DIV_EN
        div_d  = div_q;
        w_shl  = {hi_q, lo_q[WIDTH-1]};
        w_diff = w_shl - {1'b0, b_q};
`endif
        if (start_i) begin
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
            cnt_d  = '0;
            busy_d = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            div_d  = div_i;
`endif
        end else if (busy_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
                // b == 0 never borrows: quotient fills with ones, remainder ends as a_i
                if (!w_diff[WIDTH]) begin
                    hi_d = w_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = w_shl[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            if (lo_q[0]) begin
                {hi_d, lo_d} = {w_sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module : seq_alu
// Brief  : Handshaked ALU: 1-cycle logic/arith/shift ops, iterative MULU and
//          (with SEQ_ALU_DIV_EN defined) DIVU; registered Res/ResHi/Zero/Ovf.
// Rev    : 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       ALUCtr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] ResHi,
    output logic             Zero,
    output logic             Ovf
);
    import seq_alu_pkg::*;

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] w_add, w_sub, w_res1, w_lo, w_hi;
    logic [SH_W-1:0]  w_shamt;
    logic             w_ovf1, w_start, w_done;

    always_comb begin
        w_add   = In1 + In2;
        w_sub   = In1 - In2;
        w_shamt = In2[SH_W-1:0];
        w_res1  = '0;
        w_ovf1  = 1'b0;
        case (ALUCtr)
            OP_AND: w_res1 = In1 & In2;
            OP_OR:  w_res1 = In1 | In2;
            OP_NOR: w_res1 = ~(In1 | In2);
            OP_ADD: begin
                w_res1 = w_add;
                w_ovf1 = (In1[WIDTH-1] == In2[WIDTH-1]) && (w_add[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res1 = w_sub;
                w_ovf1 = (In1[WIDTH-1] != In2[WIDTH-1]) && (w_sub[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SLT: w_res1 = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            OP_SLL: w_res1 = In1 << w_shamt;
            OP_SRL: w_res1 = In1 >> w_shamt;
            OP_SRA: w_res1 = $signed(In1) >>> w_shamt;
            default: w_res1 = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        reshi_d = reshi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        w_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (ALUCtr == OP_MULU) begin
                        state_d = ST_MUL;
                        w_start = 1'b1;
`ifdef SEQ_ALU_DIV_EN
                    end else if (ALUCtr == OP_DIVU) begin
                        state_d = ST_DIV;
                        w_start = 1'b1;
`endif
                    end else begin
                        state_d = ST_DONE;
                        res_d   = w_res1;
                        reshi_d = '0;
                        zero_d  = (w_res1 == '0);
                        ovf_d   = w_ovf1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_done) begin
                    state_d = ST_DONE;
                    res_d   = w_lo;
                    reshi_d = w_hi;
                    zero_d  = (w_lo == '0);
                    ovf_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            reshi_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            reshi_q <= reshi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    seq_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start_i (w_start),
`ifdef SEQ_ALU_DIV_EN
        .div_i   (ALUCtr == OP_DIVU),
`endif
        .a_i     (In1),
        .b_i     (In2),
        .done_o  (w_done),
        .lo_o    (w_lo),
        .hi_o    (w_hi)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Res       = res_q;
    assign ResHi     = reshi_q;
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_alu
// Brief  : Self-checking bench for seq_alu (WIDTH=32); DIVU expectations follow
//          SEQ_ALU_DIV_EN.
// Rev    : 1.0
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_SLL = 4'b0011, C_SRL = 4'b0100, C_SRA = 4'b0101,
                           C_SUB = 4'b0110, C_SLT = 4'b0111, C_MUL = 4'b1000,
                           C_DIV = 4'b1001, C_NOR = 4'b1100, C_BAD = 4'b1111;

    logic         clk = 1'b0, reset = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, Zero, Ovf;
    logic [W-1:0] In1 = '0, In2 = '0, Res, ResHi;
    logic [3:0]   ALUCtr = '0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b, res, hi;
        logic         z, o;
        int           lat;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] res, hi;
        logic         z, o;
        int           lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In1       (In1),
        .In2       (In2),
        .ALUCtr    (ALUCtr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Res       (Res),
        .ResHi     (ResHi),
        .Zero      (Zero),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] hi,
                           input logic z, input logic o, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.hi = hi; v.z = z; v.o = o; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Drive one op with out_ready high; latency counts posedges from the accept edge
    // (inclusive) to the first negedge where out_valid is seen.
    task automatic run_op(input vec_t v);
        exp_t e, got;
        int   lat = 1;
        int   rdy_busy = 0;
        e.name = v.name; e.res = v.res; e.hi = v.hi; e.z = v.z; e.o = v.o; e.lat = v.lat;
        @(negedge clk);
        In1 = v.a; In2 = v.b; ALUCtr = v.op; in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_busy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready) rdy_busy++;
        got = sb.pop_front();
        chk({got.name, ".lat"},   W'(lat), W'(got.lat));
        chk({got.name, ".Res"},   Res,     got.res);
        chk({got.name, ".ResHi"}, ResHi,   got.hi);
        chk({got.name, ".Zero"},  W'(Zero), W'(got.z));
        chk({got.name, ".Ovf"},   W'(Ovf),  W'(got.o));
        chk({got.name, ".in_ready_busy"}, W'(rdy_busy), '0);
    endtask

    initial begin
        int bad;
        add_vec("add_ovf",  C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1);
        add_vec("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
        add_vec("sub_zero", C_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
        add_vec("sub_ovf1", C_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1);
        add_vec("sub_ovf2", C_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1);
        add_vec("slt_t",    C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1);
        add_vec("slt_f",    C_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
        add_vec("sra",      C_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 32'h0, 1'b0, 1'b0, 1);
        add_vec("srl_mask", C_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 32'h0, 1'b0, 1'b0, 1);
        add_vec("sll_31",   C_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1);
        add_vec("and",      C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1'b0, 1'b0, 1);
        add_vec("or",       C_OR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h0, 1'b0, 1'b0, 1);
        add_vec("nor",      C_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
        add_vec("unknown",  C_BAD, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
        add_vec("mul_max",  C_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, W + 1);
        add_vec("mul_zlo",  C_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 1'b1, 1'b0, W + 1);
        add_vec("mul_mix",  C_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h1, 1'b0, 1'b0, W + 1);
`ifdef SEQ_ALU_DIV_EN
        add_vec("div_100_7", C_DIV, 32'd100,       32'd7, 32'd14,        32'd2,       1'b0, 1'b0, W + 1);
        add_vec("div_by0",   C_DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h1234,    1'b0, 1'b0, W + 1);
        add_vec("div_small", C_DIV, 32'd5,         32'd7, 32'd0,         32'd5,       1'b1, 1'b0, W + 1);
`else
        add_vec("div_off",   C_DIV, 32'd100,       32'd7, 32'd0,         32'd0,       1'b1, 1'b0, 1);
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", W'(out_valid), '0);
        chk("rst.in_ready",  W'(in_ready),  32'd1);
        chk("rst.Res",       Res,   '0);
        chk("rst.ResHi",     ResHi, '0);
        chk("rst.Zero",      W'(Zero), '0);
        chk("rst.Ovf",       W'(Ovf),  '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end

        // back-pressure: result held while out_ready low, a waiting op is not captured
        @(negedge clk);
        In1 = 32'd3; In2 = 32'd4; ALUCtr = C_ADD; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 In1 = 32'd20; In2 = 32'd1; ALUCtr = C_SUB;
        @(negedge clk);
        chk("bp.out_valid", W'(out_valid), 32'd1);
        chk("bp.Res",       Res, 32'd7);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || in_ready || Res !== 32'd7 || ResHi !== '0 || Zero !== 1'b0 || Ovf !== 1'b0)
                bad++;
        end
        chk("bp.stable", W'(bad), '0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.retire_valid", W'(out_valid), '0);
        chk("bp.retire_ready", W'(in_ready),  32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp.next_valid", W'(out_valid), 32'd1);
        chk("bp.next_Res",   Res, 32'd19);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // asynchronous reset ten cycles into a multiply
        @(negedge clk);
        In1 = 32'hFFFF_FFFF; In2 = 32'd2; ALUCtr = C_MUL; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mrst.out_valid", W'(out_valid), '0);
        chk("mrst.in_ready",  W'(in_ready),  32'd1);
        chk("mrst.Res",       Res,   '0);
        chk("mrst.ResHi",     ResHi, '0);
        chk("mrst.Zero",      W'(Zero), '0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("mrst.no_result", W'(bad), '0);
        begin
            vec_t v;
            v.name = "mul_after_rst"; v.op = C_MUL; v.a = 32'd3; v.b = 32'd5;
            v.res = 32'd15; v.hi = '0; v.z = 1'b0; v.o = 1'b0; v.lat = W + 1;
            run_op(v);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
